core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Per-core instruction sequencer: fetches, hands instr to decoder, sequences ALU/memory ops from decode flags.
//  Updates PC (jump/branch/call/ret/exit) with an internal return-address stack; sits between imem and core datapath.
// PARAMETERS
//  ADDR_W     16  PC / instruction-address width
//  INSTR_W    32  instruction width
//  RAS_DEPTH  4   return-address stack entries (>=1)
// PORTS
//  clk           in   1        core clock
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        begin execution at start_pc (sampled in IDLE/DONE)
//  start_pc      in   ADDR_W   entry point
//  busy          out  1        high in any state except IDLE/DONE/ERROR
//  done          out  1        held high in DONE
//  error         out  1        held high in ERROR (RAS over/underflow)
//  fetch_req     out  1        fetch request, held until fetch_valid
//  fetch_addr    out  ADDR_W   = pc
//  fetch_valid   in   1        fetch_instr valid this cycle
//  fetch_instr   in   INSTR_W  fetched word
//  instr_o       out  INSTR_W  latched instr to decoder
//  dec           in   12       seq_pkg::dec_flags_t from decoder
//  branch_taken  in   1        branch condition result (valid in UPDATE)
//  target_addr   in   ADDR_W   jump/branch/call target (valid in UPDATE)
//  alu_start     out  1        1-cycle pulse: start R/I/X-type op
//  alu_done      in   1        ALU/X-unit result ready
//  mem_req       out  1        memory op request, held until mem_ack
//  mem_ack       in   1        memory op complete
//  reg_we        out  1        1-cycle register writeback strobe
//  pc_o          out  ADDR_W   current pc
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, pc=0, instr_o=0, RAS empty, every output 0.
//  FSM: IDLE -start-> FETCH -fetch_valid-> DECODE -> EXEC -> UPDATE -> FETCH | DONE | ERROR.
//  IDLE/DONE: start=1 -> pc=start_pc, RAS cleared, FETCH next cycle; DONE also clears done.
//  FETCH: fetch_req=1 until fetch_valid; same edge latches instr_o.
//  DECODE: 1 cycle; dec sampled into flag register.
//  EXEC R/I/X: alu_start 1 cycle on entry; wait alu_done (alu_done on the entry cycle is accepted).
//  EXEC load/store/streamload/storevec: mem_req held until mem_ack (mem_ack same cycle as first req OK).
//  EXEC control flow / no flags: pass through in 1 cycle.
//  UPDATE: reg_we=1 for R/I/X/load/streamload. Next pc:
//   jump -> target; branch -> taken ? target : pc+1; call -> push pc+1, target.
//   ret -> pop; exit -> DONE, pc held; else pc+1 (mod 2^ADDR_W, wraps).
//  RAS: push when full or pop when empty -> ERROR; pc unchanged; error held until reset or start.
//  Min latency, ALU op with immediate alu_done: 4 cycles/instr excl. fetch wait.
//  Multiple flags set: priority exit > ret > call > jump > branch > mem > ALU.
//  start while busy: ignored.
// CONFIGURATION
//  CORE_SEQ_PERF_EN defined: adds outputs cyc_cnt[31:0] and instr_cnt[31:0].
//   Both clear on start. cyc_cnt counts busy cycles; instr_cnt counts UPDATE cycles.
//   Both saturate at 2^32-1.
//  Undefined: ports and counters absent; no other change.
// STRUCTURE
//  seq_pkg: state_e (IDLE,FETCH,DECODE,EXEC,UPDATE,DONE,ERROR).
//  seq_pkg: dec_flags_t, packed, MSB->LSB: rtype,itype,mem_load,mem_store,streamload,storevec,x_type,branch,jump,call,ret,exit.
//  seq_pkg: ALU/MEM class helper functions.
//  Sub-module ret_stack: LIFO; inputs push, pop, din, clr; outputs dout, full, empty.
// TESTING
//  start_pc=0x10, ADDI, EXIT -> instr_o/fetch_addr 0x10,0x11; reg_we once; done; pc_o=0x11.
//  LOAD, mem_ack delayed 5 cycles -> mem_req high exactly 6 cycles; reg_we 1 cycle after.
//  BRANCH, target 0x40: taken=0 -> next fetch 0x11; taken=1 -> next fetch 0x40.
//  CALL@0x20 to 0x80, RET@0x80 -> fetch 0x80 then 0x21; RAS back to empty.
//  RAS_DEPTH=4, 5 nested CALLs -> error=1 after 5th; RET with empty RAS -> error=1.
//  rst_n low mid-EXEC with mem_req=1 -> mem_req=0 immediately; state IDLE; start restarts cleanly.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: sequencer state, decoder flag layout and op-class helpers shared by the core_sequencer slice.
package seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, UPDATE, DONE, ERROR} state_e;
  typedef struct packed {
    logic rtype;
    logic itype;
    logic mem_load;
    logic mem_store;
    logic streamload;
    logic storevec;
    logic x_type;
    logic branch;
    logic jump;
    logic call;
    logic ret;
    logic exit;
  } dec_flags_t;
  typedef enum logic [2:0] {OP_NONE, OP_ALU, OP_MEM, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET, OP_EXIT} op_e;
  function automatic logic is_alu(dec_flags_t d);
    return d.rtype | d.itype | d.x_type;
  endfunction
  function automatic logic is_mem(dec_flags_t d);
    return d.mem_load | d.mem_store | d.streamload | d.storevec;
  endfunction
  // Collapses multiple set flags into the single op that wins by priority.
  function automatic op_e op_class(dec_flags_t d);
    return d.exit ? OP_EXIT : d.ret ? OP_RET : d.call ? OP_CALL : d.jump ? OP_JUMP :
           d.branch ? OP_BRANCH : is_mem(d) ? OP_MEM : is_alu(d) ? OP_ALU : OP_NONE;
  endfunction
  function automatic logic writes_reg(dec_flags_t d);
    op_e c = op_class(d);
    return c == OP_ALU || (c == OP_MEM && (d.mem_load | d.streamload));
  endfunction
endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: fetch, decode and execution handshakes between the sequencer (master) and the core datapath (slave).
interface core_sequencer_if
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
) ();
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic [INSTR_W-1:0] instr_o;
  dec_flags_t         dec;
  logic               branch_taken;
  logic [ADDR_W-1:0]  target_addr;
  logic               alu_start;
  logic               alu_done;
  logic               mem_req;
  logic               mem_ack;
  logic               reg_we;
  modport master (
    output fetch_req, fetch_addr, instr_o, alu_start, mem_req, reg_we,
    input  fetch_valid, fetch_instr, dec, branch_taken, target_addr, alu_done, mem_ack
  );
  modport slave (
    input  fetch_req, fetch_addr, instr_o, alu_start, mem_req, reg_we,
    output fetch_valid, fetch_instr, dec, branch_taken, target_addr, alu_done, mem_ack
  );
endinterface

// File: rtl/core_sequencer_ret_stack.sv
// ret_stack: return-address LIFO with synchronous clear; push when full / pop when empty are ignored.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[IW'(cnt - CW'(1))];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (push && !full) cnt <= cnt + CW'(1);
    else if (pop && !empty) cnt <= cnt - CW'(1);
  always_ff @(posedge clk)
    if (push && !full && !clr) mem[IW'(cnt)] <= din;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: per-core fetch/decode/exec/update sequencer with internal return-address stack.
// Optional CORE_SEQ_PERF_EN adds saturating cyc_cnt/instr_cnt outputs.
module core_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int INSTR_W   = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] pc_o,
  core_sequencer_if.master  bus
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       instr_cnt
`endif
);
  state_e             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, pc_inc, ras_top;
  logic [INSTR_W-1:0] instr_q;
  dec_flags_t         flags;
  op_e                op;
  logic               first, go, push, pop, full, empty;
  assign pc_inc        = pc + ADDR_W'(1);
  assign op            = op_class(flags);
  assign go            = start && (state == IDLE || state == DONE || state == ERROR);
  assign busy          = !(state inside {IDLE, DONE, ERROR});
  assign done          = state == DONE;
  assign error         = state == ERROR;
  assign pc_o          = pc;
  assign bus.fetch_req  = state == FETCH;
  assign bus.fetch_addr = pc;
  assign bus.instr_o    = instr_q;
  assign bus.alu_start  = state == EXEC && first && op == OP_ALU;
  assign bus.mem_req    = state == EXEC && op == OP_MEM;
  assign bus.reg_we     = state == UPDATE && writes_reg(flags);
  ret_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(go),
    .din(pc_inc), .dout(ras_top), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        state_n = go ? FETCH : state;
        pc_n    = go ? start_pc : pc;
      end
      FETCH:  state_n = bus.fetch_valid ? DECODE : FETCH;
      DECODE: state_n = EXEC;
      EXEC:   state_n = op == OP_ALU ? (bus.alu_done ? UPDATE : EXEC) :
                        op == OP_MEM ? (bus.mem_ack ? UPDATE : EXEC) : UPDATE;
      UPDATE: begin
        push    = op == OP_CALL && !full;
        pop     = op == OP_RET && !empty;
        state_n = op == OP_EXIT ? DONE :
                  ((op == OP_CALL && full) || (op == OP_RET && empty)) ? ERROR : FETCH;
        // Exit and stack faults leave pc on the offending instruction.
        pc_n    = state_n != FETCH ? pc : pop ? ras_top :
                  (op inside {OP_CALL, OP_JUMP} || (op == OP_BRANCH && bus.branch_taken)) ? bus.target_addr : pc_inc;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      instr_q <= '0;
      flags   <= '0;
      first   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      first <= state == DECODE;
      if (state == FETCH && bus.fetch_valid) instr_q <= bus.fetch_instr;
      if (state == DECODE) flags <= bus.dec;
    end
`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else if (go) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy && ~&cyc_cnt) cyc_cnt <= cyc_cnt + 32'd1;
      if (state == UPDATE && ~&instr_cnt) instr_cnt <= instr_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed programs run against an ISA-level model of fetch order, writebacks and final state.
module tb_core_sequencer;
  import seq_pkg::*;
  typedef enum logic [3:0] {I_NOP, I_ADDI, I_ADD, I_LOAD, I_STORE, I_BR, I_JMP, I_CALL, I_RET, I_EXIT, I_XOP} iop_e;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] start_pc = '0;
  logic        busy, done, error;
  logic [15:0] pc_o;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif
  core_sequencer_if #(.ADDR_W(16), .INSTR_W(32)) bus ();
  core_sequencer #(.ADDR_W(16), .INSTR_W(32), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .busy(busy), .done(done), .error(error), .pc_o(pc_o), .bus(bus)
`ifdef CORE_SEQ_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );
  always #5 clk = ~clk;

  logic [31:0] imem [256];
  int fetch_lat = 0, alu_lat = 0, mem_lat = 0, fw = 0, aw = 0, mw = 0;
  logic ab = 1'b0;
  int tests = 0, fails = 0;

  function automatic logic [31:0] ins(iop_e op, logic t, logic [15:0] a);
    return {op, 11'b0, t, a};
  endfunction

  // Decoder stand-in: opcode in [31:28], taken bit [16], target [15:0].
  always_comb begin
    bus.dec = '0;
    case (iop_e'(bus.instr_o[31:28]))
      I_ADDI:  bus.dec.itype = 1'b1;
      I_ADD:   bus.dec.rtype = 1'b1;
      I_XOP:   bus.dec.x_type = 1'b1;
      I_LOAD:  bus.dec.mem_load = 1'b1;
      I_STORE: bus.dec.mem_store = 1'b1;
      I_BR:    bus.dec.branch = 1'b1;
      I_JMP:   bus.dec.jump = 1'b1;
      I_CALL:  bus.dec.call = 1'b1;
      I_RET:   bus.dec.ret = 1'b1;
      I_EXIT:  bus.dec.exit = 1'b1;
      default: ;
    endcase
    bus.branch_taken = bus.instr_o[16];
    bus.target_addr  = bus.instr_o[15:0];
  end

  // Memory / ALU responders with programmable latency.
  always @(negedge clk) begin
    if (bus.fetch_req) begin
      bus.fetch_valid = fw == fetch_lat;
      bus.fetch_instr = imem[bus.fetch_addr[7:0]];
      fw = bus.fetch_valid ? 0 : fw + 1;
    end else begin
      bus.fetch_valid = 1'b0;
      bus.fetch_instr = '0;
      fw = 0;
    end
    if (bus.mem_req) begin
      bus.mem_ack = mw == mem_lat;
      mw++;
    end else begin
      bus.mem_ack = 1'b0;
      mw = 0;
    end
    if (!rst_n) ab = 1'b0;
    else if (bus.alu_start) begin ab = 1'b1; aw = 0; end
    else if (ab) aw++;
    bus.alu_done = ab && aw == alu_lat;
    if (bus.alu_done) ab = 1'b0;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  logic [15:0] exp_fetch[$];
  logic        exp_done, exp_err, chk_on = 1'b0;
  logic [15:0] exp_pc;
  int exp_we, exp_alu;
  int cyc = 0, we_seen, alu_seen, busy_cyc, mreq_cyc, last_mreq, last_we;

  // Architectural model: walk the program, recording fetch order and end state.
  task automatic model(input logic [15:0] spc);
    logic [15:0] pc = spc;
    logic [15:0] stk[$];
    logic [31:0] w;
    iop_e op;
    exp_fetch.delete();
    exp_we = 0; exp_alu = 0; exp_done = 1'b0; exp_err = 1'b0;
    for (int n = 0; n < 64 && !exp_done && !exp_err; n++) begin
      exp_fetch.push_back(pc);
      w  = imem[pc[7:0]];
      op = iop_e'(w[31:28]);
      if (op inside {I_ADDI, I_ADD, I_XOP}) begin exp_we++; exp_alu++; end
      if (op == I_LOAD) exp_we++;
      case (op)
        I_EXIT: exp_done = 1'b1;
        I_RET:  if (stk.size() == 0) exp_err = 1'b1; else pc = stk.pop_back();
        I_CALL: if (stk.size() == 4) exp_err = 1'b1; else begin stk.push_back(pc + 16'd1); pc = w[15:0]; end
        I_JMP:  pc = w[15:0];
        I_BR:   pc = w[16] ? w[15:0] : pc + 16'd1;
        default: pc = pc + 16'd1;
      endcase
    end
    exp_pc = pc;
  endtask

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (chk_on) begin
      if (busy) busy_cyc++;
      if (bus.reg_we) begin we_seen++; last_we = cyc; end
      if (bus.alu_start) alu_seen++;
      if (bus.mem_req) begin mreq_cyc++; last_mreq = cyc; end
      chk("status_onehot", 32'($countones({busy, done, error}) <= 1), 32'd1);
      if (bus.fetch_req && bus.fetch_valid) begin
        if (exp_fetch.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_fetch: got 0x%0h expected none", bus.fetch_addr);
        end else chk("fetch_addr", bus.fetch_addr, exp_fetch.pop_front());
      end
    end
  end

  task automatic run(input string n, input logic [15:0] spc);
    model(spc);
    we_seen = 0; alu_seen = 0; busy_cyc = 0; mreq_cyc = 0; last_mreq = 0; last_we = 0;
    chk_on = 1'b1;
    start_pc = spc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !(done || error); i++) @(negedge clk);
    #2;
    chk_on = 1'b0;
    chk({n, " finished"}, done | error, 1);
    chk({n, " done"}, done, exp_done);
    chk({n, " error"}, error, exp_err);
    chk({n, " pc"}, pc_o, exp_pc);
    chk({n, " reg_we"}, we_seen, exp_we);
    chk({n, " alu_start"}, alu_seen, exp_alu);
    chk({n, " fetches left"}, exp_fetch.size(), 0);
    chk({n, " busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = ins(I_EXIT, 1'b0, 16'h0);
    #13;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst pc", pc_o, 0);
    chk("rst fetch_req", bus.fetch_req, 0);
    chk("rst mem_req", bus.mem_req, 0);
    chk("rst reg_we", bus.reg_we, 0);
    chk("rst instr_o", bus.instr_o, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    imem[8'h10] = ins(I_ADDI, 1'b0, 16'h0);
    imem[8'h11] = ins(I_EXIT, 1'b0, 16'h0);
    run("addi_exit", 16'h10);
    chk("addi_exit pc lit", pc_o, 16'h11);
    chk("addi_exit we lit", we_seen, 1);
    chk("addi_exit cycles", busy_cyc, 8);
    chk("addi_exit instr_o", bus.instr_o, 32'h9000_0000);
    imem[8'h30] = ins(I_LOAD, 1'b0, 16'h0);
    mem_lat = 5;
    run("load", 16'h30);
    chk("load mem_req cycles", mreq_cyc, 6);
    chk("load we after ack", last_we - last_mreq, 1);
    mem_lat = 0;
    imem[8'h10] = ins(I_BR, 1'b0, 16'h40);
    run("br_not_taken", 16'h10);
    chk("br_not_taken pc lit", pc_o, 16'h11);
    imem[8'h10] = ins(I_BR, 1'b1, 16'h40);
    run("br_taken", 16'h10);
    chk("br_taken pc lit", pc_o, 16'h40);
    imem[8'h20] = ins(I_CALL, 1'b0, 16'h80);
    imem[8'h80] = ins(I_RET, 1'b0, 16'h0);
    imem[8'h21] = ins(I_RET, 1'b0, 16'h0);
    run("call_ret", 16'h20);
    chk("call_ret error lit", error, 1);
    chk("call_ret pc lit", pc_o, 16'h21);
    imem[8'h50] = ins(I_CALL, 1'b0, 16'h60);
    imem[8'h60] = ins(I_CALL, 1'b0, 16'h70);
    imem[8'h70] = ins(I_CALL, 1'b0, 16'h90);
    imem[8'h90] = ins(I_CALL, 1'b0, 16'hA0);
    imem[8'hA0] = ins(I_CALL, 1'b0, 16'hB0);
    run("ras_overflow", 16'h50);
    chk("ras_overflow pc lit", pc_o, 16'hA0);
    imem[8'hC0] = ins(I_RET, 1'b0, 16'h0);
    run("ras_underflow", 16'hC0);
    chk("ras_underflow pc lit", pc_o, 16'hC0);
    fetch_lat = 3; alu_lat = 2;
    imem[8'hE0] = ins(I_ADD, 1'b0, 16'h0);
    imem[8'hE1] = ins(I_XOP, 1'b0, 16'h0);
    imem[8'hE2] = ins(I_JMP, 1'b0, 16'hFFFF);
    imem[8'hFF] = ins(I_NOP, 1'b0, 16'h0);
    fork
      run("wrap_slow", 16'hE0);
      begin
        repeat (6) @(negedge clk);
        start_pc = 16'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk("wrap_slow pc lit", pc_o, 16'h0000);
    chk("wrap_slow done lit", done, 1);
    fetch_lat = 0; alu_lat = 0; mem_lat = 20;
    start_pc = 16'h30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !bus.mem_req; i++) @(negedge clk);
    chk("mid mem_req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async mem_req", bus.mem_req, 0);
    chk("async busy", busy, 0);
    chk("async pc", pc_o, 0);
    chk("async instr_o", bus.instr_o, 0);
    @(negedge clk); rst_n = 1'b1; mem_lat = 0;
    @(negedge clk);
    imem[8'h10] = ins(I_ADDI, 1'b0, 16'h0);
    run("after_reset", 16'h10);
    chk("after_reset pc lit", pc_o, 16'h11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
